// File: rtl/usr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usr_pkg
// Description : Shared definitions for the universal shift register sequencer:
//               command op-codes, sequencer state encoding and a helper that
//               classifies multi-step (shift/rotate) operations.
// Revision    : 1.0 - initial release
// ============================================================================
package usr_pkg;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_SHR  = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_LOAD = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ASR  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_SHIFT = 1'b1;

    // Shift and rotate ops take a step count; HOLD/LOAD/CLR finish in one edge.
    function automatic logic is_shift_op(input logic [2:0] op);
        return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) ||
               (op == OP_ROL) || (op == OP_ASR);
    endfunction

endpackage : usr_pkg
`default_nettype wire

// File: rtl/usr_step.sv
`default_nettype none
// ============================================================================
// Module      : usr_step
// Description : Combinational single-step function of the shift register.
//               next_q = f(q, op, load_data, ser_in_r, ser_in_l)
// Ports       : q          current register value
//               op         operation code (usr_pkg::OP_*)
//               load_data  parallel load value
//               ser_in_r   serial bit entering at MSB on right shift
//               ser_in_l   serial bit entering at LSB on left shift
//               next_q     value after one step
// Revision    : 1.0 - initial release
// ============================================================================
module usr_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    output logic [WIDTH-1:0] next_q
);

    always_comb begin
        next_q = q;
        case (op)
            OP_HOLD: next_q = q;
            OP_SHR:  next_q = {ser_in_r, q[WIDTH-1:1]};
            OP_SHL:  next_q = {q[WIDTH-2:0], ser_in_l};
            OP_LOAD: next_q = load_data;
            OP_ROR:  next_q = {q[0], q[WIDTH-1:1]};
            OP_ROL:  next_q = {q[WIDTH-2:0], q[WIDTH-1]};
            OP_ASR:  next_q = {q[WIDTH-1], q[WIDTH-1:1]};
            OP_CLR:  next_q = '0;
            default: next_q = q;
        endcase
    end

endmodule : usr_step
`default_nettype wire

// File: rtl/universal_shift_reg_seq.sv
`default_nettype none
// ============================================================================
// Module      : universal_shift_reg_seq
// Description : WIDTH-bit universal shift register with a command sequencer.
//               An N-step shift/rotate is accepted as one command and executed
//               one position per clock with ready/busy/done handshaking.
// Ports       : clk        rising-edge clock
//               reset      asynchronous active-low reset
//               cmd_valid  command strobe; accepted when cmd_ready is high
//               cmd_ready  sequencer idle, able to accept a command
//               cmd_op     operation code (usr_pkg::OP_*)
//               cmd_amt    number of shift/rotate steps
//               load_data  parallel load value
//               ser_in_r   serial input for right shift (enters at MSB)
//               ser_in_l   serial input for left shift (enters at LSB)
//               q          register contents
//               ser_out_r  q[0]
//               ser_out_l  q[WIDTH-1]
//               busy       multi-step shift in progress
//               done       one-cycle pulse after command completion
// Revision    : 1.0 - initial release
// ============================================================================
module universal_shift_reg_seq
    import usr_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_amt,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_r,
    output logic             ser_out_l,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    logic [CNT_W-1:0] r_remaining;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_q;
    logic             r_done;

    logic             w_accept;
    logic [2:0]       w_step_op;
    logic [WIDTH-1:0] w_next_q;

    assign w_accept  = cmd_valid && (r_state == ST_IDLE);
    // The first step uses the live op at accept; later steps use the latched op
    // so changes on cmd_op while busy have no effect.
    assign w_step_op = (r_state == ST_SHIFT) ? r_op : cmd_op;

    usr_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q         (r_q),
        .op        (w_step_op),
        .load_data (load_data),
        .ser_in_r  (ser_in_r),
        .ser_in_l  (ser_in_l),
        .next_q    (w_next_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_op        <= OP_HOLD;
            r_q         <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_SHIFT) begin
                r_q         <= w_next_q;
                r_remaining <= r_remaining - CNT_W'(1);
                if (r_remaining == CNT_W'(1)) begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b1;
                end
            end else if (w_accept) begin
                r_done <= 1'b1;
                if (!is_shift_op(cmd_op)) begin
                    r_q <= w_next_q;
                end else if (cmd_amt != '0) begin
                    r_q <= w_next_q;
                    if (cmd_amt > CNT_W'(1)) begin
                        // Remaining steps run in SHIFT; done waits for the last one.
                        r_state     <= ST_SHIFT;
                        r_remaining <= cmd_amt - CNT_W'(1);
                        r_op        <= cmd_op;
                        r_done      <= 1'b0;
                    end
                end
            end
        end
    end

    assign q         = r_q;
    assign done      = r_done;
    assign busy      = (r_state == ST_SHIFT);
    assign cmd_ready = (r_state == ST_IDLE);
    assign ser_out_r = r_q[0];
    assign ser_out_l = r_q[WIDTH-1];

endmodule : universal_shift_reg_seq
`default_nettype wire

// File: tb/tb_universal_shift_reg_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_universal_shift_reg_seq
// Description : Scoreboard bench for universal_shift_reg_seq (WIDTH=8).
//               Commands push their expected final q and busy length; a
//               monitor pops and compares on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_universal_shift_reg_seq;

    localparam int W  = 8;
    localparam int CW = $clog2(W) + 1;

    localparam logic [2:0] HOLD = 3'd0, SHR = 3'd1, SHL = 3'd2, LOAD = 3'd3,
                           ROR = 3'd4, ROL = 3'd5, ASR = 3'd6, CLR = 3'd7;

    typedef struct {
        logic [W-1:0] q;
        int           busy_cycles;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = 3'd0;
    logic [CW-1:0] cmd_amt = '0;
    logic [W-1:0]  load_data = '0;
    logic          ser_in_r = 1'b0;
    logic          ser_in_l = 1'b0;
    logic [W-1:0]  q;
    logic          ser_out_r, ser_out_l, busy, done;

    exp_t          sb[$];
    int            vectors = 0;
    int            miscompares = 0;
    logic [W-1:0]  m_q = '0;

    universal_shift_reg_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_amt   (cmd_amt),
        .load_data (load_data),
        .ser_in_r  (ser_in_r),
        .ser_in_l  (ser_in_l),
        .q         (q),
        .ser_out_r (ser_out_r),
        .ser_out_l (ser_out_l),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Reference: whole-command result from arithmetic on the step count.
    function automatic logic [W-1:0] model(input logic [W-1:0] cur, input logic [2:0] op,
                                           input int amt, input logic [W-1:0] data,
                                           input logic sr, input logic sl);
        int unsigned v    = cur;
        int unsigned mask = (1 << W) - 1;
        int          k    = amt % W;
        int unsigned fill;
        case (op)
            HOLD: return cur;
            LOAD: return data;
            CLR:  return '0;
            SHR: begin
                if (amt >= W) return sr ? W'(mask) : '0;
                fill = sr ? (mask & ~(mask >> amt)) : 0;
                return W'((v >> amt) | fill);
            end
            SHL: begin
                if (amt >= W) return sl ? W'(mask) : '0;
                fill = sl ? ((1 << amt) - 1) : 0;
                return W'(((v << amt) & mask) | fill);
            end
            ROR: return (k == 0) ? cur : W'(((v >> k) | (v << (W - k))) & mask);
            ROL: return (k == 0) ? cur : W'(((v << k) | (v >> (W - k))) & mask);
            ASR: begin
                if (amt >= W) return cur[W-1] ? W'(mask) : '0;
                return W'($signed(cur) >>> amt);
            end
            default: return cur;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one command; ser inputs stay at these values until the next command.
    task automatic issue(input logic [2:0] op, input int amt, input logic [W-1:0] data,
                         input logic sr, input logic sl, input bit expect_done);
        int   guard = 0;
        exp_t e;
        while (!cmd_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!cmd_ready) check("ready_timeout", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_amt   = CW'(amt);
        load_data = data;
        ser_in_r  = sr;
        ser_in_l  = sl;
        if (expect_done) begin
            m_q           = model(m_q, op, amt, data, sr, sl);
            e.q           = m_q;
            e.busy_cycles = ((op == SHR || op == SHL || op == ROR || op == ROL || op == ASR)
                             && amt >= 2) ? amt - 1 : 0;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    // Monitor: counts busy cycles and checks the scoreboard on each done pulse.
    initial begin : mon
        int   busy_cnt = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                busy_cnt = 0;
            end else begin
                if (busy && cmd_ready) check("busy_vs_ready", 32'd1, 32'd0);
                if (busy) busy_cnt++;
                if (done) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", 32'(done), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("q", 32'(q), 32'(e.q));
                        check("busy_len", 32'(busy_cnt), 32'(e.busy_cycles));
                        check("ser_out_r", 32'(ser_out_r), 32'(e.q[0]));
                        check("ser_out_l", 32'(ser_out_l), 32'(e.q[W-1]));
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    initial begin : stim
        logic [2:0] rop;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_q", 32'(q), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_ready", 32'(cmd_ready), 32'h1);

        // Directed cases
        issue(LOAD, 0, 8'hB4, 0, 0, 1);
        issue(CLR,  0, 8'h00, 0, 0, 1);
        issue(LOAD, 0, 8'hB4, 0, 0, 1);
        issue(SHR,  3, 8'h00, 1, 0, 1);          // -> 0xF6
        issue(LOAD, 0, 8'hB4, 0, 0, 1);
        issue(ROL,  1, 8'h00, 0, 0, 1);          // -> 0x69
        issue(LOAD, 0, 8'hB4, 0, 0, 1);
        issue(ROL,  8, 8'h00, 0, 0, 1);          // -> 0xB4, busy 7
        issue(SHL,  2, 8'h00, 0, 0, 1);          // -> 0xD0
        issue(LOAD, 0, 8'h84, 0, 0, 1);
        issue(ASR,  2, 8'h00, 0, 0, 1);          // -> 0xE1
        issue(SHR,  0, 8'h00, 1, 1, 1);          // unchanged
        issue(SHR, 15, 8'h00, 1, 0, 1);          // all-fill

        // Command during busy must be ignored
        issue(LOAD, 0, 8'h5A, 0, 0, 1);
        issue(SHR,  5, 8'h00, 0, 0, 1);
        cmd_valid = 1'b1;
        cmd_op    = LOAD;
        cmd_amt   = CW'(1);
        load_data = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        drain();

        // Reset mid-SHIFT aborts without done
        issue(LOAD, 0, 8'hC3, 0, 0, 1);
        drain();
        issue(ROL, 8, 8'h00, 0, 0, 0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("abort_q", 32'(q), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        m_q = '0;
        repeat (10) @(posedge clk);
        #1;
        issue(LOAD, 0, 8'h3C, 0, 0, 1);

        // Randomized commands, back-to-back where possible
        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 7));
            issue(rop, $urandom_range(0, 15), W'($urandom), 1'($urandom), 1'($urandom), 1);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_universal_shift_reg_seq
`default_nettype wire
